hamming_decoder: RTL and testbench



---
 rtl/hamming_decoder_pkg.sv | 18 +
 rtl/hamming_decoder_if.sv | 20 ++
 rtl/hamming_syndrome_correct.sv | 13 +
 rtl/hamming_decoder.sv | 73 +++++++
 tb/tb_hamming_decoder.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/hamming_decoder_pkg.sv
// hamming_decoder_pkg: shared Hamming(7,4) widths, parity positions and syndrome helper.
package hamming_decoder_pkg;
   localparam int CW_W = 7;
   localparam int DATA_W = 4;
   localparam int SYN_W = 3;
   localparam int P1 = 1;
   localparam int P2 = 2;
   localparam int P4 = 4;

   // Each syndrome bit is the parity over every position whose index contains that parity bit.
   function automatic logic [SYN_W-1:0] syndrome(input logic [CW_W:1] c);
      logic [SYN_W-1:0] s;
      s = '0;
      for (int i = 1; i <= CW_W; i++)
         s ^= {(i & P4) != 0, (i & P2) != 0, (i & P1) != 0} & {SYN_W{c[i]}};
      return s;
   endfunction
endpackage

// File: rtl/hamming_decoder_if.sv
// hamming_decoder_if: codeword-in / data-out valid-ready channel of the decoder.
interface hamming_decoder_if;
   import hamming_decoder_pkg::*;
   logic in_valid;
   logic in_ready;
   logic [CW_W:1] in_codeword;
   logic out_valid;
   logic out_ready;
   logic [DATA_W-1:0] out_data;
   logic [SYN_W-1:0] out_syndrome;
   logic out_corrected;
   modport slave (
      input in_valid, in_codeword, out_ready,
      output in_ready, out_valid, out_data, out_syndrome, out_corrected
   );
   modport master (
      output in_valid, in_codeword, out_ready,
      input in_ready, out_valid, out_data, out_syndrome, out_corrected
   );
endinterface

// File: rtl/hamming_syndrome_correct.sv
// hamming_syndrome_correct: combinational syndrome and single-bit correction of a 7-bit codeword.
module hamming_syndrome_correct
   import hamming_decoder_pkg::*;
(
   input  logic [CW_W:1]      cw,
   output logic [SYN_W-1:0]   syn,
   output logic [CW_W:1]      fixed
);
   assign syn = syndrome(cw);
   for (genvar g = 1; g <= CW_W; g++) begin : g_fix
      assign fixed[g] = cw[g] ^ (syn == SYN_W'(g));
   end
endmodule

// File: rtl/hamming_decoder.sv
// hamming_decoder: two-stage Hamming(7,4) SEC decoder with valid/ready handshake and delivery counters.
module hamming_decoder
   import hamming_decoder_pkg::*;
(
   input  logic                 clock,
   input  logic                 reset_n,
   hamming_decoder_if.slave     bus,
   output logic [15:0]          word_count,
   output logic [7:0]           corr_count
);
   logic s1_valid;
   logic [CW_W:1] s1_cw;
   logic [SYN_W-1:0] s1_syn;
   logic [SYN_W-1:0] sc_syn;
   logic [CW_W:1] fixed;
   logic out_valid;
   logic [DATA_W-1:0] out_data;
   logic [SYN_W-1:0] out_syn;
   logic out_corr;
   logic s2_adv;
   logic in_fire;
   logic out_fire;

   assign s2_adv = s1_valid && (!out_valid || bus.out_ready);
   assign bus.in_ready = !s1_valid || s2_adv;
   assign in_fire = bus.in_valid && bus.in_ready;
   assign out_fire = out_valid && bus.out_ready;
   assign bus.out_valid = out_valid;
   assign bus.out_data = out_data;
   assign bus.out_syndrome = out_syn;
   assign bus.out_corrected = out_corr;

   hamming_syndrome_correct u_sc (
      .cw    (s1_cw),
      .syn   (sc_syn),
      .fixed (fixed)
   );

   always_ff @(posedge clock or negedge reset_n)
      if (!reset_n) begin
         s1_valid <= 1'b0;
         s1_cw <= '0;
         s1_syn <= '0;
      end else if (in_fire) begin
         s1_valid <= 1'b1;
         s1_cw <= bus.in_codeword;
         s1_syn <= syndrome(bus.in_codeword);
      end else if (s2_adv)
         s1_valid <= 1'b0;

   always_ff @(posedge clock or negedge reset_n)
      if (!reset_n) begin
         out_valid <= 1'b0;
         out_data <= '0;
         out_syn <= '0;
         out_corr <= 1'b0;
      end else if (s2_adv) begin
         out_valid <= 1'b1;
         out_data <= {fixed[7], fixed[6], fixed[5], fixed[3]};
         out_syn <= s1_syn;
         out_corr <= |sc_syn;
      end else if (bus.out_ready)
         out_valid <= 1'b0;

   always_ff @(posedge clock or negedge reset_n)
      if (!reset_n) begin
         word_count <= '0;
         corr_count <= '0;
      end else if (out_fire) begin
         word_count <= word_count + 16'd1;
         corr_count <= (out_corr && corr_count != 8'hFF) ? corr_count + 8'd1 : corr_count;
      end
endmodule

// File: tb/tb_hamming_decoder.sv
// tb_hamming_decoder: directed-vector self-checking bench for hamming_decoder.
module tb_hamming_decoder;
   import hamming_decoder_pkg::*;

   logic clock = 1'b0;
   logic reset_n = 1'b0;
   logic [15:0] word_count;
   logic [7:0] corr_count;
   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   int n_out = 0;
   int first_out = 0;
   int last_out = 0;
   bit bp_done;
   logic [6:0] exp_q[$];
   logic [6:0] mon_e;

   hamming_decoder_if bus();

   hamming_decoder dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .bus        (bus),
      .word_count (word_count),
      .corr_count (corr_count)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:1] enc(input logic [3:0] d);
      return {d[3], d[2], d[1], d[1] ^ d[2] ^ d[3], d[0], d[0] ^ d[2] ^ d[3], d[0] ^ d[1] ^ d[3]};
   endfunction

   function automatic logic [7:1] flip(input logic [7:1] cw, input int idx);
      return idx == 0 ? cw : cw ^ (7'b1 << (idx - 1));
   endfunction

   task automatic sync();
      @(posedge clock);
      #1;
   endtask

   // Must be entered just after a rising edge; returns just after the accepting edge.
   task automatic send(input logic [3:0] d, input int idx);
      bus.in_codeword = flip(enc(d), idx);
      bus.in_valid = 1'b1;
      for (int t = 0; ; t++) begin
         @(negedge clock);
         if (bus.in_ready) break;
         if (t == 40) begin
            check("in_ready_timeout", 32'd0, 32'd1);
            bus.in_valid = 1'b0;
            return;
         end
      end
      exp_q.push_back({d, 3'(idx)});
      sync();
      bus.in_valid = 1'b0;
   endtask

   task automatic drain();
      for (int t = 0; t < 200 && exp_q.size() != 0; t++) @(negedge clock);
      repeat (2) @(negedge clock);
      check("drain", 32'(exp_q.size()), 32'd0);
   endtask

   always @(negedge clock)
      if (reset_n && bus.out_valid && bus.out_ready) begin
         if (exp_q.size() == 0)
            check("spurious_out", 32'd1, 32'd0);
         else begin
            mon_e = exp_q.pop_front();
            check("out_data", 32'(bus.out_data), 32'(mon_e[6:3]));
            check("out_syndrome", 32'(bus.out_syndrome), 32'(mon_e[2:0]));
            check("out_corrected", 32'(bus.out_corrected), 32'(mon_e[2:0] != 3'd0));
         end
         if (n_out == 0) first_out = cyc;
         last_out = cyc;
         n_out++;
      end

   initial begin
      bus.in_valid = 1'b0;
      bus.in_codeword = '0;
      bus.out_ready = 1'b1;
      repeat (2) sync();
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_out_data", 32'(bus.out_data), 32'd0);
      check("rst_out_syndrome", 32'(bus.out_syndrome), 32'd0);
      check("rst_out_corrected", 32'(bus.out_corrected), 32'd0);
      check("rst_word_count", 32'(word_count), 32'd0);
      check("rst_corr_count", 32'(corr_count), 32'd0);
      reset_n = 1'b1;
      @(negedge clock);
      check("in_ready_after_rst", 32'(bus.in_ready), 32'd1);
      // Clean word 7'b1010101 carries data 4'b1011.
      sync();
      send(4'b1011, 0);
      @(negedge clock);
      check("lat_s1", 32'(bus.out_valid), 32'd0);
      @(negedge clock);
      check("lat_s2", 32'(bus.out_valid), 32'd1);
      @(negedge clock);
      check("clean_word_count", 32'(word_count), 32'd1);
      check("clean_corr_count", 32'(corr_count), 32'd0);
      // 7'b1000101 (bit 5 flipped) and 7'b0000100 (bit 3 flipped on zero word).
      sync();
      send(4'b1011, 5);
      send(4'b0000, 3);
      drain();
      check("single_word_count", 32'(word_count), 32'd3);
      check("single_corr_count", 32'(corr_count), 32'd2);
      // All data values times all corruption indices, back to back.
      sync();
      n_out = 0;
      for (int d = 0; d < 16; d++)
         for (int idx = 0; idx < 8; idx++) send(4'(d), idx);
      drain();
      check("exh_outputs", 32'(n_out), 32'd128);
      check("exh_span", 32'(last_out - first_out), 32'd127);
      // Backpressure: five words against a stalled output.
      sync();
      n_out = 0;
      bp_done = 1'b0;
      bus.out_ready = 1'b0;
      fork
         begin
            for (int i = 1; i <= 5; i++) send(4'(i), i);
            bp_done = 1'b1;
         end
      join_none
      repeat (3) @(negedge clock);
      check("bp_data_n2", 32'(bus.out_data), 32'd1);
      check("bp_syn_n2", 32'(bus.out_syndrome), 32'd1);
      @(negedge clock);
      check("bp_in_ready", 32'(bus.in_ready), 32'd0);
      check("bp_accepted", 32'(exp_q.size()), 32'd2);
      check("bp_out_valid", 32'(bus.out_valid), 32'd1);
      check("bp_data_n3", 32'(bus.out_data), 32'd1);
      check("bp_syn_n3", 32'(bus.out_syndrome), 32'd1);
      sync();
      bus.out_ready = 1'b1;
      for (int t = 0; t < 100 && !bp_done; t++) @(negedge clock);
      check("bp_sender_done", 32'(bp_done), 32'd1);
      drain();
      check("bp_outputs", 32'(n_out), 32'd5);
      // Correction counter saturation.
      sync();
      for (int i = 0; i < 300; i++) send(4'(i % 16), 1 + i % 7);
      drain();
      check("corr_saturate", 32'(corr_count), 32'hFF);
      // Asynchronous reset between edges, mid-stream.
      sync();
      send(4'h9, 2);
      send(4'h6, 4);
      send(4'hC, 0);
      bus.in_codeword = enc(4'h3);
      bus.in_valid = 1'b1;
      #2 reset_n = 1'b0;
      #1;
      check("arst_out_valid", 32'(bus.out_valid), 32'd0);
      check("arst_word_count", 32'(word_count), 32'd0);
      check("arst_corr_count", 32'(corr_count), 32'd0);
      bus.in_valid = 1'b0;
      exp_q.delete();
      @(negedge clock);
      reset_n = 1'b1;
      sync();
      check("arst_in_ready", 32'(bus.in_ready), 32'd1);
      n_out = 0;
      send(4'h3, 6);
      @(negedge clock);
      check("arst_lat_s1", 32'(bus.out_valid), 32'd0);
      @(negedge clock);
      check("arst_lat_s2", 32'(bus.out_valid), 32'd1);
      drain();
      check("arst_outputs", 32'(n_out), 32'd1);
      check("arst_word_count_after", 32'(word_count), 32'd1);
      check("arst_corr_count_after", 32'(corr_count), 32'd1);
      // Word counter wrap: 65535 words reach 16'hFFFF, one more wraps to 0.
      sync();
      reset_n = 1'b0;
      sync();
      reset_n = 1'b1;
      sync();
      for (int i = 0; i < 65535; i++) send(4'(i), 0);
      drain();
      check("wc_ffff", 32'(word_count), 32'hFFFF);
      sync();
      send(4'h5, 0);
      drain();
      check("wc_wrap", 32'(word_count), 32'd0);
      check("wc_wrap_corr", 32'(corr_count), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
